// File: rtl/div16_seq_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div16_seq_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div16_seq_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] r_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit so a partial remainder near 2^WIDTH-1 can't wrap.
  assign shifted = {r_i, msb_i};
  assign trial   = shifted - {1'b0, y_i};
  assign qbit_o  = ~trial[WIDTH];
  assign r_o     = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned divider, one quotient bit per clock, start/ready/done handshake.
module div16_seq
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_qbit;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i    (r_q),
    .msb_i  (dividend_q[WIDTH-1]),
    .y_i    (divisor_q),
    .r_o    (step_r),
    .qbit_o (step_qbit)
  );

  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    r_d        = r_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          dividend_d = x;
          divisor_d  = y;
          r_d        = '0;
          cnt_d      = '0;
          dbz_d      = 1'b0;
          if (y == '0) begin
            state_d = DONE;
            quot_d  = {WIDTH{&DIV_ZERO_QUOT}};
            rem_d   = x;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Quotient bits fill the dividend register from the LSB as it empties.
        dividend_d = {dividend_q[WIDTH-2:0], step_qbit};
        r_d        = step_r;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = {dividend_q[WIDTH-2:0], step_qbit};
          rem_d   = step_r;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      r_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      r_q        <= r_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign ready       = (state_q != RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Directed and randomised checks of the sequential divider handshake and results.
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div16_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x           (x),
    .y           (y),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Launch one op and wait (bounded) for done; lat=1 means done the cycle after accept.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] ya, output int lat);
    x = xa;
    y = ya;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b done=%b q=%h r=%h dbz=%b, want 1 0 0000 0000 0", ready, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    $display("reset released: ready=%b done=%b", ready, done);
  endtask

  task automatic test_basic();
    int lat;
    x = 16'd100;
    y = 16'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: ready=%b done=%b, want 0 0", ready, done);
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 17 || ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency: lat=%0d ready=%b, want 17 1", lat, ready);
    end
    total++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want 14 2 0", quotient, remainder, div_by_zero);
    end
    $display("op 100/7: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || quotient !== 16'd14) begin
      bad++;
      $display("FAIL basic_pulse: done=%b q=%0d, want 0 14", done, quotient);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] vx [3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
    logic [15:0] vy [3] = '{16'h0001, 16'hFFFF, 16'hFFFF};
    logic [15:0] eq [3] = '{16'hFFFF, 16'h0001, 16'h0000};
    logic [15:0] er [3] = '{16'h0000, 16'h0000, 16'h8000};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(vx[i], vy[i], lat);
      total++;
      if (lat !== 17 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL boundary_%0d: lat=%0d q=%h r=%h dbz=%b, want 17 %h %h 0", i, lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      $display("op %h/%h: q=%h r=%h lat=%0d", vx[i], vy[i], quotient, remainder, lat);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(16'd5, 16'd0, lat);
    total++;
    if (lat !== 1 || quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: lat=%0d q=%h r=%0d dbz=%b, want 1 ffff 5 1", lat, quotient, remainder, div_by_zero);
    end
    $display("op 5/0: q=%h r=%0d dbz=%b lat=%0d", quotient, remainder, div_by_zero, lat);
    @(posedge clk); #1;
    x = 16'd9;
    y = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (div_by_zero !== 1'b0 || quotient !== 16'hFFFF || ready !== 1'b0) begin
      bad++;
      $display("FAIL dbz_clear: dbz=%b q=%h ready=%b, want 0 ffff 0", div_by_zero, quotient, ready);
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 17 || quotient !== 16'd3 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL after_zero: lat=%0d q=%0d r=%0d dbz=%b, want 17 3 0 0", lat, quotient, remainder, div_by_zero);
    end
    $display("op 9/3: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    x = 16'd3;
    y = 16'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'd50;
    y = 16'd5;
    lat = 1;
    while (!done && lat < 40) begin
      start = (lat == 4 || lat == 10);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat !== 17 || quotient !== 16'd0 || remainder !== 16'd3) begin
      bad++;
      $display("FAIL ignored_start: lat=%0d q=%0d r=%0d, want 17 0 3", lat, quotient, remainder);
    end
    $display("op 3/10: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    // Start while done is high must be accepted on the same edge done falls.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0 || ready !== 1'b0 || remainder !== 16'd3) begin
      bad++;
      $display("FAIL b2b_accept: done=%b ready=%b r=%0d, want 0 0 3", done, ready, remainder);
    end
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 17 || quotient !== 16'd10 || remainder !== 16'd0) begin
      bad++;
      $display("FAIL b2b_result: lat=%0d q=%0d r=%0d, want 17 10 0", lat, quotient, remainder);
    end
    $display("op 50/5: q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    x = 16'd1000;
    y = 16'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: ready=%b done=%b q=%0d r=%0d dbz=%b, want 1 0 0 0 0", ready, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0 || quotient !== 16'd0) begin
      bad++;
      $display("FAIL abort_no_done: done_cycles=%0d q=%0d, want 0 0", seen, quotient);
    end
    $display("op 1000/9 aborted by reset: done_cycles=%0d", seen);
  endtask

  task automatic test_random();
    logic [15:0] rx, ry, eq, er;
    logic        ez;
    int lat;
    for (int i = 0; i < 500; i++) begin
      rx = 16'($urandom);
      case (i % 4)
        0: ry = 16'($urandom);
        1: ry = 16'($urandom_range(1, 20));
        2: ry = (i % 20 == 2) ? 16'd0 : 16'($urandom_range(1, 300));
        default: ry = 16'($urandom) | 16'h8000;
      endcase
      if (ry == 16'd0) begin
        eq = 16'hFFFF; er = rx; ez = 1'b1;
      end else begin
        eq = rx / ry; er = rx % ry; ez = 1'b0;
      end
      do_op(rx, ry, lat);
      total++;
      if (lat !== (ez ? 1 : 17) || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        bad++;
        $display("FAIL random_%0d: %h/%h lat=%0d q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b", i, rx, ry, lat, quotient, remainder, div_by_zero, eq, er, ez);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("FAIL random_pulse_%0d: done=%b ready=%b, want 0 1", i, done, ready);
      end
    end
    $display("random: 500 ops issued");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
